dpd_capture_sequencer: RTL and testbench
========================================

DPD_CAPTURE_SEQUENCER -- requirements
Module: dpd_capture_sequencer

Interface
REQ-001 SHALL have parameter DLY_W, default 16, width of the trig_delay and interval counters.
REQ-002 SHALL have parameter CNT_W, default 8, width of num_caps and cap_index.
REQ-003 SHALL have parameter TO_W, default 20, width of the capture-timeout counter.
REQ-004 SHALL have port data_clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port data_rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port arm  in  1  single-cycle pulse that starts a capture sequence.
REQ-007 SHALL have port abort  in  1  single-cycle pulse that stops any sequence.
REQ-008 SHALL have port trig_src  in  1  0 = start immediately, 1 = wait for an ext_trig rising edge.
REQ-009 SHALL have port ext_trig  in  1  external trigger level, already synchronous to data_clk.
REQ-010 SHALL have port trig_delay  in  DLY_W  cycles between trigger qualification and the first cap_trigger.
REQ-011 SHALL have port num_caps  in  CNT_W  captures per sequence; 0 = continuous until abort.
REQ-012 SHALL have port interval  in  DLY_W  idle cycles between a cap_done and the next cap_trigger.
REQ-013 SHALL have port cap_done  in  1  done level from the capture buffer; falls 1 cycle after cap_trigger and rises when the buffer is full.
REQ-014 SHALL have port cap_trigger  out  1  single-cycle pulse that starts one buffer capture.
REQ-015 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-016 SHALL have port seq_done  out  1  sticky flag; set on normal completion, cleared by arm.
REQ-017 SHALL have port timeout_err  out  1  sticky flag; set on capture timeout, cleared by arm.
REQ-018 SHALL have port cap_index  out  CNT_W  number of completed captures in the current sequence.

Function
REQ-019 SHALL implement the states IDLE, WAIT_TRIG, DELAY, FIRE, CAPTURE and INTERVAL.
REQ-020 SHALL, when arm is seen in IDLE, latch trig_src, trig_delay, num_caps and interval; clear cap_index, seq_done and timeout_err; then go to WAIT_TRIG.
REQ-021 SHALL ignore later changes to the configuration inputs until the next accepted arm.
REQ-022 SHALL ignore arm when the state is not IDLE.
REQ-023 SHALL leave WAIT_TRIG for DELAY when latched trig_src = 0, or when a rising edge is seen on ext_trig (ext_trig = 1 and the registered copy = 0).
REQ-024 SHALL load the delay counter with the latched trig_delay when it enters DELAY.
REQ-025 SHALL decrement the delay counter each cycle in DELAY and go to FIRE in the cycle the counter is 0.
REQ-026 SHALL hold cap_trigger at 1 for exactly the one cycle spent in FIRE, then go to CAPTURE.
REQ-027 SHALL place cap_trigger 3+D cycles after the arm cycle, where D = trig_delay, for trig_src = 0.
REQ-028 SHALL, in CAPTURE, wait for a rising edge of cap_done (cap_done = 1 and the registered copy = 0).
REQ-029 SHALL, as a consequence of REQ-028, never treat a cap_done that is still high from an earlier capture as completion.
REQ-030 SHALL, on that cap_done edge, increment cap_index (modulo 2^CNT_W).
REQ-031 SHALL, if latched num_caps != 0 and the new cap_index equals num_caps, set seq_done and go to IDLE.
REQ-032 SHALL otherwise load the interval counter with the latched interval and go to INTERVAL.
REQ-033 SHALL count the interval counter down in INTERVAL and go to FIRE at 0, without waiting for a trigger again.
REQ-034 SHALL clear the timeout counter when it enters CAPTURE and increment it each CAPTURE cycle.
REQ-035 SHALL, if the timeout counter reaches 2^TO_W-1 without a cap_done edge, set timeout_err, leave cap_index unchanged and go to IDLE.
REQ-036 SHALL, on abort in any state, go to IDLE the next cycle, leave seq_done at 0 and keep cap_index.
REQ-037 SHALL give abort priority over arm, trigger, a cap_done edge and a timeout that occur in the same cycle.
REQ-038 SHALL, when a cap_done edge and a timeout occur in the same cycle, treat the capture as completed and leave timeout_err clear.
REQ-039 SHALL, with num_caps = 0, keep cycling FIRE -> CAPTURE -> INTERVAL until abort or timeout, with cap_index wrapping from 2^CNT_W-1 to 0.
REQ-040 SHALL drive busy, seq_done, timeout_err and cap_trigger from registers (no combinational path from inputs).

Reset
REQ-041 SHALL, while data_rstn = 0, force state IDLE, cap_trigger 0, busy 0, seq_done 0, timeout_err 0, cap_index 0, all counters 0 and the edge registers 0.
REQ-042 SHALL, on reset asserted mid-sequence, drop busy with no further cap_trigger, and respond to the first arm after release.

Verification (the capture model drops cap_done 1 cycle after cap_trigger and raises it 2048 cycles later)
REQ-043 SHALL check: trig_src = 0, trig_delay = 5, num_caps = 1, arm in cycle 0 -> cap_trigger only in cycle 8; seq_done = 1 and busy = 0 after the cap_done edge; cap_index = 1.
REQ-044 SHALL check: trig_src = 1, ext_trig held high before arm -> no cap_trigger; a later 0->1 on ext_trig -> cap_trigger 3 cycles later (delay = 0).
REQ-045 SHALL check: num_caps = 3, interval = 10 -> exactly 3 cap_trigger pulses, each 11 cycles after the previous cap_done edge; final cap_index = 3.
REQ-046 SHALL check: TO_W = 6 and a model that never raises cap_done -> timeout_err = 1 and busy = 0 after 63 CAPTURE cycles; the next arm clears timeout_err.
REQ-047 SHALL check: num_caps = 0, abort and arm in the same cycle in INTERVAL -> IDLE, no new sequence, seq_done = 0.
REQ-048 SHALL check: data_rstn pulsed low during DELAY -> all outputs 0 immediately; a fresh arm then yields a normal sequence.

Source files
------------

// File: rtl/dpd_capture_sequencer.sv
// DPD capture sequencer.
// Arms on a pulse and waits for an immediate or external trigger. After a
// programmable delay it issues one cap_trigger pulse per buffer capture and
// waits for the buffer's done edge. Between captures it waits a programmable
// interval. A capture that never completes is caught by a timeout.
module dpd_capture_sequencer #(
    parameter int unsigned DLY_W = 16,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TO_W  = 20
) (
    input  logic             data_clk,
    input  logic             data_rstn,
    input  logic             arm,
    input  logic             abort,
    input  logic             trig_src,
    input  logic             ext_trig,
    input  logic [DLY_W-1:0] trig_delay,
    input  logic [CNT_W-1:0] num_caps,
    input  logic [DLY_W-1:0] interval,
    input  logic             cap_done,
    output logic             cap_trigger,
    output logic             busy,
    output logic             seq_done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] cap_index
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TRIG,
        DELAY,
        FIRE,
        CAPTURE,
        INTERVAL
    } state_t;

    // The timeout fires on the cycle whose increment would make the counter
    // reach all-ones, which gives exactly 2^TO_W-1 CAPTURE cycles.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t             state;
    logic               trig_src_l;
    logic [DLY_W-1:0]   trig_delay_l;
    logic [CNT_W-1:0]   num_caps_l;
    logic [DLY_W-1:0]   interval_l;
    // One down-counter serves both DELAY and INTERVAL. The two states never
    // overlap, so they cannot interfere.
    logic [DLY_W-1:0]   wait_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               ext_trig_q;
    logic               cap_done_q;

    logic               ext_rise;
    logic               done_rise;
    logic [CNT_W-1:0]   cap_index_inc;

    assign ext_rise      = ext_trig & ~ext_trig_q;
    // An edge is required, so a done level left high by the previous capture
    // can never complete the current one.
    assign done_rise     = cap_done & ~cap_done_q;
    assign cap_index_inc = cap_index + 1'b1;

    // Sequencer FSM with all outputs and counters registered
    always_ff @(posedge data_clk or negedge data_rstn) begin
        if (!data_rstn) begin
            state        <= IDLE;
            trig_src_l   <= 1'b0;
            trig_delay_l <= '0;
            num_caps_l   <= '0;
            interval_l   <= '0;
            wait_cnt     <= '0;
            to_cnt       <= '0;
            ext_trig_q   <= 1'b0;
            cap_done_q   <= 1'b0;
            cap_trigger  <= 1'b0;
            busy         <= 1'b0;
            seq_done     <= 1'b0;
            timeout_err  <= 1'b0;
            cap_index    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout. Every branch below
            // reads the pre-edge values of state and the counters, which is
            // what a flop does.
            ext_trig_q  <= ext_trig;
            cap_done_q  <= cap_done;
            cap_trigger <= 1'b0;

            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            trig_src_l   <= trig_src;
                            trig_delay_l <= trig_delay;
                            num_caps_l   <= num_caps;
                            interval_l   <= interval;
                            cap_index    <= '0;
                            seq_done     <= 1'b0;
                            timeout_err  <= 1'b0;
                            busy         <= 1'b1;
                            state        <= WAIT_TRIG;
                        end
                    end

                    WAIT_TRIG: begin
                        if (!trig_src_l || ext_rise) begin
                            wait_cnt <= trig_delay_l;
                            state    <= DELAY;
                        end
                    end

                    DELAY, INTERVAL: begin
                        if (wait_cnt == '0) begin
                            cap_trigger <= 1'b1;
                            state       <= FIRE;
                        end else begin
                            wait_cnt <= wait_cnt - 1'b1;
                        end
                    end

                    FIRE: begin
                        to_cnt <= '0;
                        state  <= CAPTURE;
                    end

                    CAPTURE: begin
                        to_cnt <= to_cnt + 1'b1;
                        // A done edge wins over a timeout in the same cycle.
                        if (done_rise) begin
                            cap_index <= cap_index_inc;
                            if ((num_caps_l != '0) && (cap_index_inc == num_caps_l)) begin
                                seq_done <= 1'b1;
                                busy     <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                wait_cnt <= interval_l;
                                state    <= INTERVAL;
                            end
                        end else if (to_cnt == TO_LAST) begin
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end

                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dpd_capture_sequencer.sv
// Testbench for dpd_capture_sequencer.
// The main instance drives a buffer model that drops cap_done one cycle after
// cap_trigger and raises it again 2048 cycles later. A second instance, built
// with TO_W = 6, drives a buffer model that never completes, to exercise the
// timeout. Expected cap_trigger cycles go into queues when a sequence is
// armed, and a monitor pops one entry for every pulse it sees.
module tb_dpd_capture_sequencer;

    localparam int DLY_W    = 16;
    localparam int CNT_W    = 8;
    localparam int TO_W     = 20;
    localparam int TO_W_T   = 6;
    localparam int BUF_FILL = 2048;

    logic             data_clk  = 1'b0;
    logic             data_rstn = 1'b0;

    // Main instance
    logic             arm        = 1'b0;
    logic             abort      = 1'b0;
    logic             trig_src   = 1'b0;
    logic             ext_trig   = 1'b0;
    logic [DLY_W-1:0] trig_delay = '0;
    logic [CNT_W-1:0] num_caps   = '0;
    logic [DLY_W-1:0] interval   = '0;
    logic             cap_done   = 1'b1;
    logic             cap_trigger;
    logic             busy;
    logic             seq_done;
    logic             timeout_err;
    logic [CNT_W-1:0] cap_index;

    // Timeout instance
    logic             arm_t      = 1'b0;
    logic             abort_t    = 1'b0;
    logic             cap_done_t = 1'b1;
    logic             cap_trigger_t;
    logic             busy_t;
    logic             seq_done_t;
    logic             timeout_err_t;
    logic [CNT_W-1:0] cap_index_t;

    int cyc = 0;
    int mcnt = 0;
    int n_checks = 0;
    int n_pass = 0;
    int exp_q[$];
    int exp_t_q[$];
    int exp_val;
    int exp_val_t;

    dpd_capture_sequencer #(.DLY_W(DLY_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
        .data_clk   (data_clk),
        .data_rstn  (data_rstn),
        .arm        (arm),
        .abort      (abort),
        .trig_src   (trig_src),
        .ext_trig   (ext_trig),
        .trig_delay (trig_delay),
        .num_caps   (num_caps),
        .interval   (interval),
        .cap_done   (cap_done),
        .cap_trigger(cap_trigger),
        .busy       (busy),
        .seq_done   (seq_done),
        .timeout_err(timeout_err),
        .cap_index  (cap_index)
    );

    dpd_capture_sequencer #(.DLY_W(DLY_W), .CNT_W(CNT_W), .TO_W(TO_W_T)) dut_to (
        .data_clk   (data_clk),
        .data_rstn  (data_rstn),
        .arm        (arm_t),
        .abort      (abort_t),
        .trig_src   (1'b0),
        .ext_trig   (1'b0),
        .trig_delay (16'd0),
        .num_caps   (8'd1),
        .interval   (16'd0),
        .cap_done   (cap_done_t),
        .cap_trigger(cap_trigger_t),
        .busy       (busy_t),
        .seq_done   (seq_done_t),
        .timeout_err(timeout_err_t),
        .cap_index  (cap_index_t)
    );

    always #5 data_clk = ~data_clk;

    always @(posedge data_clk) cyc <= cyc + 1;

    // Capture buffer: done drops after a trigger, rises BUF_FILL cycles later
    always @(posedge data_clk) begin
        if (cap_trigger) begin
            cap_done <= 1'b0;
            mcnt     <= BUF_FILL;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) cap_done <= 1'b1;
        end
    end

    // Stuck capture buffer: done drops after a trigger and never rises
    always @(posedge data_clk) begin
        if (cap_trigger_t) cap_done_t <= 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor for the main instance: each cap_trigger pulse consumes one expectation
    always @(negedge data_clk) begin
        if (cap_trigger) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_cap_trigger: pulse at cycle %0d, none expected", cyc);
            end else begin
                exp_val = exp_q.pop_front();
                check("cap_trigger_cycle", cyc, exp_val);
            end
        end
    end

    // Monitor for the timeout instance
    always @(negedge data_clk) begin
        if (cap_trigger_t) begin
            if (exp_t_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_cap_trigger_t: pulse at cycle %0d, none expected", cyc);
            end else begin
                exp_val_t = exp_t_q.pop_front();
                check("cap_trigger_t_cycle", cyc, exp_val_t);
            end
        end
    end

    task automatic tick();
        @(posedge data_clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, c1, k, f1, f2, f3, e1;

        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_cap_trigger", cap_trigger, 0);
        check("rst_seq_done", seq_done, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_cap_index", cap_index, 0);
        data_rstn = 1'b1;
        tick();

        // Immediate start, delay 5, single capture: trigger in cycle 3+5
        trig_src = 1'b0; trig_delay = 5; num_caps = 1; interval = 0;
        c0 = cyc;
        exp_q.push_back(c0 + 8);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        // Configuration changes after arm must not take effect
        trig_delay = 100; num_caps = 7;
        // Done edge at trigger+1+2048; the sequence ends one cycle later
        wait_until(c0 + 8 + 2049);
        check("t1_busy_at_edge", busy, 1);
        tick();
        check("t1_seq_done", seq_done, 1);
        check("t1_busy", busy, 0);
        check("t1_cap_index", cap_index, 1);

        // External trigger: a level already high at arm does not count
        trig_src = 1'b1; ext_trig = 1'b1; trig_delay = 0; num_caps = 1;
        tick();
        c0 = cyc;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t2_seq_done_cleared", seq_done, 0);
        check("t2_cap_index_cleared", cap_index, 0);
        // An arm while waiting is ignored; if taken it would start immediately
        wait_until(c0 + 5);
        trig_src = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        wait_until(c0 + 10);
        check("t2_busy_waiting", busy, 1);
        ext_trig = 1'b0;
        tick();
        ext_trig = 1'b1;
        k = cyc;
        // Rising cycle, DELAY (count 0), FIRE: third cycle from the rise
        exp_q.push_back(k + 2);
        wait_until(k + 2 + 2049 + 1);
        check("t2_seq_done", seq_done, 1);
        check("t2_cap_index", cap_index, 1);

        // Three captures with interval 10: trigger, 2049 cycles to the done
        // edge, 11 INTERVAL cycles, then FIRE
        trig_src = 1'b0; ext_trig = 1'b0; trig_delay = 2; num_caps = 3; interval = 10;
        tick();
        c0 = cyc;
        f1 = c0 + 5;
        f2 = f1 + 2049 + 12;
        f3 = f2 + 2049 + 12;
        exp_q.push_back(f1);
        exp_q.push_back(f2);
        exp_q.push_back(f3);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        wait_until(f3);
        check("t3_cap_index_mid", cap_index, 2);
        check("t3_seq_done_mid", seq_done, 0);
        wait_until(f3 + 2049 + 1);
        check("t3_seq_done", seq_done, 1);
        check("t3_cap_index", cap_index, 3);
        check("t3_busy", busy, 0);

        // Timeout instance: 63 CAPTURE cycles, then idle with the error set
        tick();
        c0 = cyc;
        exp_t_q.push_back(c0 + 3);
        arm_t = 1'b1;
        tick();
        arm_t = 1'b0;
        wait_until(c0 + 66);
        check("t4_busy_last_capture", busy_t, 1);
        check("t4_timeout_not_yet", timeout_err_t, 0);
        tick();
        check("t4_busy", busy_t, 0);
        check("t4_timeout_err", timeout_err_t, 1);
        check("t4_cap_index", cap_index_t, 0);
        check("t4_seq_done", seq_done_t, 0);
        arm_t = 1'b1;
        tick();
        arm_t = 1'b0;
        check("t4_rearm_clears_timeout", timeout_err_t, 0);
        abort_t = 1'b1;
        tick();
        abort_t = 1'b0;
        check("t4_abort_busy", busy_t, 0);

        // Continuous mode: abort together with arm during INTERVAL
        trig_delay = 0; num_caps = 0; interval = 10;
        tick();
        c0 = cyc;
        f1 = c0 + 3;
        e1 = f1 + 2049;
        exp_q.push_back(f1);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        wait_until(e1 + 5);
        check("t5_busy_interval", busy, 1);
        check("t5_cap_index_interval", cap_index, 1);
        abort = 1'b1;
        arm = 1'b1;
        tick();
        abort = 1'b0;
        arm = 1'b0;
        check("t5_busy_after_abort", busy, 0);
        check("t5_seq_done", seq_done, 0);
        check("t5_cap_index_kept", cap_index, 1);
        wait_until(e1 + 30);
        check("t5_no_restart", busy, 0);

        // Reset during DELAY, then a fresh sequence
        trig_delay = 20; num_caps = 1; interval = 0;
        tick();
        c0 = cyc;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        wait_until(c0 + 6);
        check("t6_busy_in_delay", busy, 1);
        data_rstn = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cap_trigger", cap_trigger, 0);
        check("t6_rst_seq_done", seq_done, 0);
        check("t6_rst_timeout_err", timeout_err, 0);
        check("t6_rst_cap_index", cap_index, 0);
        tick();
        tick();
        data_rstn = 1'b1;
        wait_until(c0 + 30);
        check("t6_idle_after_reset", busy, 0);
        trig_delay = 5;
        c1 = cyc;
        exp_q.push_back(c1 + 8);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t6_busy_after_arm", busy, 1);
        wait_until(c1 + 8 + 2049 + 1);
        check("t6_seq_done", seq_done, 1);
        check("t6_cap_index", cap_index, 1);

        tick();
        tick();
        check("all_triggers_seen", exp_q.size(), 0);
        check("all_triggers_seen_t", exp_t_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
